// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad scan controller: scan FSM states, scan-result
// classes, the key code type and the row-drive helpers.
package keypad_pkg;
  typedef enum logic [1:0] {DRIVE, SAMPLE, EVAL} scan_state_e;
  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} scan_res_e;
  typedef logic [3:0] key_code_t;

  localparam logic [3:0] ROW_RESET = 4'b1110;

  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction
endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Consumer-side bundle of the keypad controller: event handshake, hold status
// and sticky overflow with its clear.
interface keypad_scan_ctrl_if;
  import keypad_pkg::*;

  key_code_t key_code;
  logic      key_valid;
  logic      key_ack;
  logic      key_held;
  logic      ovf_clr;
  logic      overflow;

  modport master (output key_code, key_valid, key_held, overflow,
                  input  key_ack, ovf_clr);
  modport slave  (input  key_code, key_valid, key_held, overflow,
                  output key_ack, ovf_clr);
endinterface

// File: rtl/key_event_fifo.sv
// Synchronous event FIFO; a pop on empty is ignored and a push on full lands
// only if a pop happens in the same cycle, otherwise drop_o flags the loss.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             pop_ok, push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~push_ok;
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner with whole-matrix debounce and an event FIFO.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key stays held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int DWELL_CYC      = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 swc,
  output logic [3:0]                 swr,
  keypad_scan_ctrl_if.master         kp
);
  localparam int DW  = $clog2(DWELL_CYC + 1);
  localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);

  if (DWELL_CYC < 1 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("keypad_scan_ctrl: invalid parameter set");
  end

  scan_state_e    state_q;
  logic [1:0]     row_q;
  logic [DW-1:0]  dwell_q;
  logic [3:0]     swr_q;
  logic [15:0]    cap_q;
  scan_res_e      prev_cls_q, stab_cls_q;
  key_code_t      prev_code_q, stab_code_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           ovf_q;

  logic [4:0]     n_low;
  scan_res_e      res_cls;
  key_code_t      res_code, push_code;
  logic           same, accept, push, rep_fire;
  logic           fifo_empty, fifo_full, fifo_drop;
  key_code_t      fifo_dout;

  // cap_q bit index equals the key code {row, col}, so a lone low bit names the key
  always_comb begin
    n_low    = '0;
    res_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (!cap_q[i]) begin
        n_low    = n_low + 5'd1;
        res_code = 4'(i);
      end
    end
    res_cls = (n_low == 5'd0) ? RES_NONE : ((n_low == 5'd1) ? RES_KEY : RES_MULTI);

    same = (res_cls == prev_cls_q) && (res_cls != RES_KEY || res_code == prev_code_q);
    if (res_cls == RES_MULTI)                      db_cnt_d = '0;
    else if (same && db_cnt_q != DBW'(DEBOUNCE_SCANS)) db_cnt_d = db_cnt_q + DBW'(1);
    else if (same)                                 db_cnt_d = db_cnt_q;
    else                                           db_cnt_d = DBW'(1);

    accept = (res_cls != RES_MULTI) && (db_cnt_d == DBW'(DEBOUNCE_SCANS)) &&
             !((res_cls == stab_cls_q) && (res_cls == RES_NONE || res_code == stab_code_q));

    push      = (state_q == EVAL) && ((accept && res_cls == RES_KEY) || rep_fire);
    push_code = accept ? res_code : stab_code_q;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW     = $clog2(REP_MAX + 1);

  logic [RPW-1:0] rep_cnt_q, rep_inc;
  logic           rep_first_q;

  assign rep_inc  = rep_cnt_q + RPW'(1);
  assign rep_fire = (state_q == EVAL) && (stab_cls_q == RES_KEY) && !accept &&
                    (rep_inc == (rep_first_q ? RPW'(REPEAT_DELAY) : RPW'(REPEAT_RATE)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (state_q == EVAL) begin
      if (accept || stab_cls_q != RES_KEY) begin
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b1;
      end else if (rep_fire) begin
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b0;
      end else begin
        rep_cnt_q   <= rep_inc;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DRIVE;
      row_q       <= '0;
      dwell_q     <= '0;
      swr_q       <= ROW_RESET;
      cap_q       <= '1;
      prev_cls_q  <= RES_NONE;
      prev_code_q <= '0;
      stab_cls_q  <= RES_NONE;
      stab_code_q <= '0;
      db_cnt_q    <= '0;
    end else begin
      case (state_q)
        DRIVE: begin
          if (dwell_q == DW'(DWELL_CYC - 1)) begin
            dwell_q <= '0;
            state_q <= SAMPLE;
          end else begin
            dwell_q <= dwell_q + DW'(1);
          end
        end
        SAMPLE: begin
          cap_q[{row_q, 2'b00} +: 4] <= swc;
          if (row_q == 2'd3) begin
            state_q <= EVAL;
          end else begin
            row_q   <= row_q + 2'd1;
            swr_q   <= row_drive(row_q + 2'd1);
            state_q <= DRIVE;
          end
        end
        EVAL: begin
          prev_cls_q  <= res_cls;
          prev_code_q <= res_code;
          db_cnt_q    <= db_cnt_d;
          if (accept) begin
            stab_cls_q  <= res_cls;
            stab_code_q <= res_code;
          end
          row_q   <= '0;
          swr_q   <= ROW_RESET;
          state_q <= DRIVE;
        end
        default: state_q <= DRIVE;
      endcase
    end
  end

  key_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (kp.key_ack),
    .din_i   (push_code),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= fifo_drop | (ovf_q & ~kp.ovf_clr);
  end

  assign swr          = swr_q;
  assign kp.key_valid = ~fifo_empty;
  assign kp.key_code  = fifo_empty ? '0 : fifo_dout;
  assign kp.key_held  = (stab_cls_q == RES_KEY);
  assign kp.overflow  = ovf_q;
endmodule
